// File: rtl/allocator_pkg.sv
// Shared types for the allocator header load/store unit: data width, the
// null pointer value, operation codes and the request/response structs.
package allocator_pkg;

    localparam int unsigned DATA_W = 32;
    localparam logic [DATA_W-1:0] NULL_ADDR = '0;

    // Number of address bits below word granularity (forced to zero on the bus).
    localparam int unsigned ALIGN_W = $clog2(DATA_W / 8);

    typedef enum logic [1:0] {
        LSU_LOAD_HEADER,
        LSU_STORE_HEADER,
        LSU_STORE_SIZE,
        LSU_STORE_NEXT
    } lsu_op_e;

    typedef struct packed {
        logic [DATA_W-1:0] size;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] next_addr;
    } header_data_t;

    typedef struct packed {
        logic         val;
        lsu_op_e      lsu_op;
        header_data_t header_data;
    } header_data_req_t;

    typedef struct packed {
        logic         val;
        header_data_t header_data;
    } header_data_rsp_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_SIZE,
        RD_NEXT,
        WR_SIZE,
        WR_NEXT,
        RSP
    } lsu_state_e;

endpackage

// File: rtl/header_lsu.sv
// Header load/store unit: moves an allocator block header (size word at addr,
// next pointer word at addr+NEXT_OFFSET) between the core and a single-port
// memory with a req/gnt/rvalid handshake. One access in flight at a time.
module header_lsu
    import allocator_pkg::*;
#(
    parameter int unsigned NEXT_OFFSET = DATA_W / 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  header_data_req_t        req_i,
    output logic                    lsu_ready_o,
    output header_data_rsp_t        rsp_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [DATA_W-1:0]       mem_addr_o,
    output logic [DATA_W-1:0]       mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_W-1:0]       mem_rdata_i
);

    localparam logic [DATA_W-1:0] NEXT_OFF_W = DATA_W'(NEXT_OFFSET);
    localparam logic [DATA_W-1:0] ALIGN_MASK = {{(DATA_W - ALIGN_W){1'b1}}, {ALIGN_W{1'b0}}};

    lsu_state_e   state_q, state_d;
    lsu_op_e      op_q, op_d;
    header_data_t hdr_q, hdr_d;         // registered request; size reused as read buffer
    header_data_t rsp_hdr_q, rsp_hdr_d; // response payload, held between responses
    logic         rd_wait_q, rd_wait_d; // read granted, waiting for rvalid

    logic is_rd, is_wr, rd_done, wr_done;
    logic [DATA_W-1:0] next_word_addr;

    // Wrap-around is intentional: the sum is taken modulo 2^DATA_W.
    assign next_word_addr = hdr_q.addr + NEXT_OFF_W;

    assign is_rd   = (state_q == RD_SIZE) || (state_q == RD_NEXT);
    assign is_wr   = (state_q == WR_SIZE) || (state_q == WR_NEXT);
    // rvalid only counts once our own read has been granted, so stray or
    // pre-reset rvalids never complete an access.
    assign rd_done = is_rd && rd_wait_q && mem_rvalid_i;
    assign wr_done = is_wr && mem_gnt_i;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_i.val) begin
                    case (req_i.lsu_op)
                        LSU_LOAD_HEADER:  state_d = (req_i.header_data.addr == NULL_ADDR) ? RSP : RD_SIZE;
                        LSU_STORE_HEADER: state_d = WR_SIZE;
                        LSU_STORE_SIZE:   state_d = WR_SIZE;
                        LSU_STORE_NEXT:   state_d = WR_NEXT;
                        default:          state_d = IDLE;
                    endcase
                end
            end
            RD_SIZE: if (rd_done) state_d = RD_NEXT;
            RD_NEXT: if (rd_done) state_d = RSP;
            WR_SIZE: if (wr_done) state_d = (op_q == LSU_STORE_HEADER) ? WR_NEXT : RSP;
            WR_NEXT: if (wr_done) state_d = RSP;
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; bus fields come only from registers so they stay stable
    // while a request waits for its grant.
    always_comb begin
        logic [DATA_W-1:0] raw_addr;
        lsu_ready_o = (state_q == IDLE);
        rsp_o.val   = (state_q == RSP);
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        raw_addr    = hdr_q.addr;
        mem_wdata_o = hdr_q.size;
        case (state_q)
            RD_SIZE: mem_req_o = !rd_wait_q;
            RD_NEXT: begin
                mem_req_o = !rd_wait_q;
                raw_addr  = next_word_addr;
            end
            WR_SIZE: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
            end
            WR_NEXT: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                raw_addr    = next_word_addr;
                mem_wdata_o = hdr_q.next_addr;
            end
            default: ;
        endcase
        mem_addr_o = raw_addr & ALIGN_MASK;
    end

    assign rsp_o.header_data = rsp_hdr_q;

    // Datapath next-state: capture request, track read grant, collect read data
    always_comb begin
        op_d      = op_q;
        hdr_d     = hdr_q;
        rsp_hdr_d = rsp_hdr_q;
        rd_wait_d = rd_wait_q;
        if (state_q == IDLE && req_i.val) begin
            op_d  = req_i.lsu_op;
            hdr_d = req_i.header_data;
            if (req_i.lsu_op == LSU_LOAD_HEADER && req_i.header_data.addr == NULL_ADDR) begin
                rsp_hdr_d.size      = '0;
                rsp_hdr_d.addr      = req_i.header_data.addr;
                rsp_hdr_d.next_addr = NULL_ADDR;
            end
        end
        if (is_rd && mem_req_o && mem_gnt_i) rd_wait_d = 1'b1;
        if (rd_done) begin
            rd_wait_d = 1'b0;
            if (state_q == RD_SIZE) begin
                hdr_d.size = mem_rdata_i;
            end else begin
                rsp_hdr_d.size      = hdr_q.size;
                rsp_hdr_d.addr      = hdr_q.addr;
                rsp_hdr_d.next_addr = mem_rdata_i;
            end
        end
        // Stores echo the registered request once the last write is granted.
        if (wr_done && state_d == RSP) rsp_hdr_d = hdr_q;
    end

    // Datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q      <= LSU_LOAD_HEADER;
            hdr_q     <= '0;
            rsp_hdr_q <= '0;
            rd_wait_q <= 1'b0;
        end else begin
            op_q      <= op_d;
            hdr_q     <= hdr_d;
            rsp_hdr_q <= rsp_hdr_d;
            rd_wait_q <= rd_wait_d;
        end
    end

endmodule

// File: tb/tb_header_lsu.sv
// Randomized bench for header_lsu: a behavioural memory with configurable
// grant/rvalid delays and a word-level reference model of each operation.
module tb_header_lsu;
    import allocator_pkg::*;

    localparam int unsigned OFF = DATA_W / 8;

    logic              clk_i = 1'b0;
    logic              rst_i;
    header_data_req_t  req_i;
    logic              lsu_ready_o;
    header_data_rsp_t  rsp_o;
    logic              mem_req_o, mem_we_o;
    logic [DATA_W-1:0] mem_addr_o, mem_wdata_o;
    logic              mem_gnt_i, mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;

    header_lsu #(.NEXT_OFFSET(OFF)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .lsu_ready_o  (lsu_ready_o),
        .rsp_o        (rsp_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- memory model ----------------
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    logic [31:0] pre [logic [31:0]];     // preset contents (main process)
    logic [31:0] mem [logic [31:0]];     // contents written by DUT (memory process)
    logic [31:0] ref_mem [logic [31:0]]; // reference model view
    acc_t        acc_q [$];              // every granted access, in order

    int gnt_dly = 0;
    int rv_dly  = 0;
    bit rnd_dly = 0;
    bit spur    = 0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        if (pre.exists(a)) return pre[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        if (pre.exists(a)) return pre[a];
        return init_word(a);
    endfunction

    initial begin
        bit          in_wait = 0, rd_pend = 0, g_last = 0;
        int          gcnt = 0, rcnt = 0;
        logic        hw = 0;
        logic [31:0] ha = '0, hd = '0, rdat = '0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            mem_gnt_i    = 0;
            mem_rvalid_i = 0;
            if (g_last) begin
                g_last = 0;
                if (!hw) begin
                    rd_pend = 1;
                    rcnt    = rnd_dly ? $urandom_range(0, 3) : rv_dly;
                    rdat    = mem_rd(ha);
                end
            end
            if (rd_pend) begin
                chk("one_outstanding", 32'(mem_req_o), 32'd0);
                if (rcnt == 0) begin
                    mem_rvalid_i = 1; mem_rdata_i = rdat; rd_pend = 0;
                end else rcnt--;
            end
            if (mem_req_o) begin
                if (in_wait) begin
                    chk("stable_we", 32'(mem_we_o), 32'(hw));
                    chk("stable_addr", mem_addr_o, ha);
                    chk("stable_wdata", mem_wdata_o, hd);
                end else begin
                    in_wait = 1;
                    gcnt = rnd_dly ? $urandom_range(0, 3) : gnt_dly;
                    hw = mem_we_o; ha = mem_addr_o; hd = mem_wdata_o;
                end
                if (gcnt == 0) begin
                    mem_gnt_i = 1; g_last = 1; in_wait = 0;
                    acc_q.push_back({hw, ha, hw ? hd : mem_rd(ha)});
                    if (hw) mem[ha] = hd;
                end else gcnt--;
            end else begin
                in_wait = 0;
                if (spur && $urandom_range(0, 3) == 0) mem_gnt_i = 1;
                if (spur && !rd_pend && !mem_rvalid_i && $urandom_range(0, 3) == 0) begin
                    mem_rvalid_i = 1; mem_rdata_i = $urandom;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic void model(input lsu_op_e op, input header_data_t h,
                                  output header_data_t r, output acc_t ex[$]);
        logic [31:0] a0, a1;
        ex = {};
        r  = h;
        a0 = h.addr & ~32'h3;
        a1 = (h.addr + OFF) & ~32'h3;
        case (op)
            LSU_LOAD_HEADER: begin
                if (h.addr == NULL_ADDR) begin
                    r.size = 0; r.next_addr = NULL_ADDR;
                end else begin
                    r.size = ref_rd(a0); r.next_addr = ref_rd(a1);
                    ex.push_back({1'b0, a0, r.size});
                    ex.push_back({1'b0, a1, r.next_addr});
                end
            end
            LSU_STORE_HEADER: begin
                ex.push_back({1'b1, a0, h.size});
                ex.push_back({1'b1, a1, h.next_addr});
            end
            LSU_STORE_SIZE: ex.push_back({1'b1, a0, h.size});
            default:        ex.push_back({1'b1, a1, h.next_addr});
        endcase
    endfunction

    function automatic header_data_t rnd_hdr();
        header_data_t h;
        h.size = $urandom; h.addr = $urandom; h.next_addr = $urandom;
        return h;
    endfunction

    function automatic header_data_t mk(input logic [31:0] s, input logic [31:0] a, input logic [31:0] n);
        header_data_t h;
        h.size = s; h.addr = a; h.next_addr = n;
        return h;
    endfunction

    // Called at a negedge; returns at the negedge after the response cycle.
    task automatic run_op(input lsu_op_e op, input header_data_t h, input int exp_lat,
                          input bit hold, input lsu_op_e op2, input header_data_t h2,
                          output int waits);
        header_data_t e;
        acc_t ex[$];
        int base, a0;
        bit seen;
        model(op, h, e, ex);
        base = acc_q.size();
        req_i.val = 1'b1; req_i.lsu_op = op; req_i.header_data = h;
        waits = 0;
        while (!lsu_ready_o && waits < 100) begin
            @(negedge clk_i); waits++;
        end
        chk("accept_ready", 32'(lsu_ready_o), 32'd1);
        a0 = cyc;
        @(posedge clk_i); #1;
        if (!hold) req_i.val = 1'b0;
        req_i.header_data = rnd_hdr();
        req_i.lsu_op = lsu_op_e'(2'($urandom_range(0, 3)));
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk_i);
            if (rsp_o.val) seen = 1;
            else if (hold) req_i.header_data = rnd_hdr();
        end
        chk("rsp_seen", 32'(seen), 32'd1);
        if (seen) begin
            if (exp_lat > 0) chk("latency", 32'(cyc - a0), 32'(exp_lat));
            chk("rsp_size", rsp_o.header_data.size, e.size);
            chk("rsp_addr", rsp_o.header_data.addr, e.addr);
            chk("rsp_next", rsp_o.header_data.next_addr, e.next_addr);
            if (hold) begin req_i.lsu_op = op2; req_i.header_data = h2; end
            @(negedge clk_i);
            chk("rsp_one_cycle", 32'(rsp_o.val), 32'd0);
            chk("rsp_hold_size", rsp_o.header_data.size, e.size);
            chk("rsp_hold_next", rsp_o.header_data.next_addr, e.next_addr);
            chk("ready_after_rsp", 32'(lsu_ready_o), 32'd1);
        end
        chk("n_access", 32'(acc_q.size() - base), 32'(ex.size()));
        for (int i = 0; i < ex.size() && base + i < acc_q.size(); i++) begin
            chk("acc_we", 32'(acc_q[base+i].we), 32'(ex[i].we));
            chk("acc_addr", acc_q[base+i].addr, ex[i].addr);
            if (ex[i].we) chk("acc_wdata", acc_q[base+i].data, ex[i].data);
        end
        foreach (ex[i]) if (ex[i].we) ref_mem[ex[i].addr] = ex[i].data;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, base;
        header_data_t h;
        lsu_op_e op;
        rst_i = 1'b1;
        req_i = '0;
        repeat (3) @(negedge clk_i);
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_mem_we", 32'(mem_we_o), 32'd0);
        chk("rst_rsp_val", 32'(rsp_o.val), 32'd0);
        chk("rst_rsp_size", rsp_o.header_data.size, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("ready_after_rst", 32'(lsu_ready_o), 32'd1);

        // zero-wait load of a preset header
        pre[32'h100] = 32'h40; pre[32'h104] = 32'h200;
        run_op(LSU_LOAD_HEADER, mk(32'h7, 32'h100, 32'h9), 5, 0, LSU_LOAD_HEADER, '0, w);
        chk("load_size_const", rsp_o.header_data.size, 32'h40);
        chk("load_next_const", rsp_o.header_data.next_addr, 32'h200);

        // latency of the remaining ops with zero-wait memory
        run_op(LSU_STORE_HEADER, mk(32'h11, 32'h300, 32'h22), 3, 0, LSU_LOAD_HEADER, '0, w);
        run_op(LSU_STORE_SIZE, mk(32'h33, 32'h308, 32'h44), 2, 0, LSU_LOAD_HEADER, '0, w);
        run_op(LSU_STORE_NEXT, mk(32'h55, 32'h310, 32'h66), 2, 0, LSU_LOAD_HEADER, '0, w);

        // null load: no memory traffic, one-cycle response
        run_op(LSU_LOAD_HEADER, mk(32'hDEAD, NULL_ADDR, 32'hBEEF), 1, 0, LSU_LOAD_HEADER, '0, w);

        // store header with grants delayed 3 cycles
        gnt_dly = 3;
        run_op(LSU_STORE_HEADER, mk(32'h20, 32'h200, 32'h0), 0, 0, LSU_LOAD_HEADER, '0, w);
        gnt_dly = 0;

        // store next with wrap-around of the pointer address
        run_op(LSU_STORE_NEXT, mk(32'h1, 32'hFFFF_FFFC, 32'h80), 2, 0, LSU_LOAD_HEADER, '0, w);
        chk("wrap_mem0", mem_rd(32'h0), 32'h80);

        // misaligned load address is truncated
        run_op(LSU_LOAD_HEADER, mk(32'h0, 32'h203, 32'h0), 5, 0, LSU_LOAD_HEADER, '0, w);

        // reset after the first read grant, rvalid arrives after reset
        rv_dly = 3;
        pre[32'h400] = 32'h1234; pre[32'h404] = 32'h5678;
        base = acc_q.size();
        req_i.val = 1'b1; req_i.lsu_op = LSU_LOAD_HEADER; req_i.header_data = mk(0, 32'h400, 0);
        @(posedge clk_i); #1;
        req_i.val = 1'b0;
        @(negedge clk_i);          // RD_SIZE request granted at the next edge
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            chk("rst_abandon_rsp", 32'(rsp_o.val), 32'd0);
            chk("rst_abandon_ready", 32'(lsu_ready_o), 32'd1);
            chk("rst_abandon_req", 32'(mem_req_o), 32'd0);
        end
        chk("rst_abandon_acc", 32'(acc_q.size() - base), 32'd1);
        chk("rst_cleared_rsp", rsp_o.header_data.next_addr, 32'd0);
        rv_dly = 0;
        run_op(LSU_LOAD_HEADER, mk(0, 32'h400, 0), 5, 0, LSU_LOAD_HEADER, '0, w);

        // request held high with changing data; the queued op follows at once
        run_op(LSU_LOAD_HEADER, mk(0, 32'h100, 0), 5, 1, LSU_STORE_SIZE, mk(32'hAB, 32'h500, 32'h0), w);
        run_op(LSU_STORE_SIZE, mk(32'hAB, 32'h500, 32'h0), 2, 0, LSU_LOAD_HEADER, '0, w);
        chk("held_accept_wait", 32'(w), 32'd0);

        // randomized traffic with random delays and stray grant/rvalid pulses
        rnd_dly = 1; spur = 1;
        for (int n = 0; n < 200; n++) begin
            op = lsu_op_e'(2'($urandom_range(0, 3)));
            h  = rnd_hdr();
            case ($urandom_range(0, 9))
                0:       h.addr = NULL_ADDR;
                1:       h.addr = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
                default: h.addr = 32'h1000 + 32'($urandom_range(0, 63));
            endcase
            if ($urandom_range(0, 2) == 0) h.next_addr = NULL_ADDR;
            run_op(op, h, 0, 0, LSU_LOAD_HEADER, '0, w);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk_i);
        end
        rnd_dly = 0; spur = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
